rs232_tx_channel_arbiter: RTL and testbench

Shares one byte-wide AXI-stream link, the input of the RS232 transmit path toward the FT2232, among CHANNELS independent AXI-stream byte sources. It arbitrates round-robin in bursts of up to MAX_BURST bytes. It inserts an escape-coded channel header whenever the transmitting channel changes and byte-stuffs payload bytes equal to the escape value. This lets the host demultiplex the serial stream back into per-channel streams.

---
 rtl/rs232_tx_channel_arbiter.sv | 141 ++++++++++++++
 tb/tb_rs232_tx_channel_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_tx_channel_arbiter.sv
// Round-robin byte mux of CHANNELS AXI-stream sources onto the single RS232 transmit stream.
// Inserts ESC,channel headers on channel changes and doubles payload ESC bytes so the host can demultiplex.
module rs232_tx_channel_arbiter #(
    parameter int CHANNELS  = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [8*CHANNELS-1:0] idata,
    input  logic [CHANNELS-1:0]   ivalid,
    output logic [CHANNELS-1:0]   iready,
    output logic [7:0]            odata,
    output logic                  ovalid,
    input  logic                  oready
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NW = $clog2(MAX_BURST + 1);
    localparam logic [7:0]    ESC       = 8'hFE;
    localparam logic [NW-1:0] BURST_MAX = NW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, HDR_CH, DATA, STUFF} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] grant, grant_nx;
    logic [CW-1:0] ptr, ptr_nx;
    logic [CW-1:0] last_ch, last_ch_nx;
    logic          have_ch, have_ch_nx;
    logic [NW-1:0] count, count_nx;
    logic          load;
    logic [7:0]    load_data;
    logic          free;
    logic          found;
    logic [CW-1:0] pick;
    logic [CW-1:0] grant_inc;
    logic [7:0]    cur_byte;
    int            scan_idx;

    assign free      = !ovalid || oready;
    assign cur_byte  = idata[8*grant +: 8];
    assign grant_inc = (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;

    // First requester at or after ptr, wrapping at CHANNELS.
    always_comb begin
        found    = 1'b0;
        pick     = ptr;
        scan_idx = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            scan_idx = int'(ptr) + i;
            if (scan_idx >= CHANNELS) scan_idx = scan_idx - CHANNELS;
            if (!found && ivalid[scan_idx]) begin
                found = 1'b1;
                pick  = CW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        ptr_nx     = ptr;
        last_ch_nx = last_ch;
        have_ch_nx = have_ch;
        count_nx   = count;
        load       = 1'b0;
        load_data  = ESC;
        iready     = '0;
        case (state)
            IDLE: begin
                if (found && free) begin
                    grant_nx = pick;
                    count_nx = '0;
                    // A header is needed whenever the stream's current channel changes.
                    if (!have_ch || pick != last_ch) begin
                        load      = 1'b1;
                        load_data = ESC;
                        state_nx  = HDR_CH;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            HDR_CH: begin
                if (free) begin
                    load       = 1'b1;
                    load_data  = 8'(grant);
                    last_ch_nx = grant;
                    have_ch_nx = 1'b1;
                    count_nx   = '0;
                    state_nx   = DATA;
                end
            end
            DATA: begin
                if (!ivalid[grant] || count == BURST_MAX) begin
                    state_nx = IDLE;
                    ptr_nx   = grant_inc;
                end else if (free) begin
                    iready[grant] = 1'b1;
                    load          = 1'b1;
                    load_data     = cur_byte;
                    count_nx      = count + 1'b1;
                    if (cur_byte == ESC) state_nx = STUFF;
                end
            end
            STUFF: begin
                // Second half of a doubled ESC; does not count toward the burst.
                if (free) begin
                    load      = 1'b1;
                    load_data = ESC;
                    state_nx  = DATA;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            grant   <= '0;
            ptr     <= '0;
            last_ch <= '0;
            have_ch <= 1'b0;
            count   <= '0;
            odata   <= 8'h00;
            ovalid  <= 1'b0;
        end else begin
            state   <= state_nx;
            grant   <= grant_nx;
            ptr     <= ptr_nx;
            last_ch <= last_ch_nx;
            have_ch <= have_ch_nx;
            count   <= count_nx;
            if (load) begin
                odata  <= load_data;
                ovalid <= 1'b1;
            end else if (oready) begin
                ovalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rs232_tx_channel_arbiter.sv
// Bench for rs232_tx_channel_arbiter: per-channel source queues, a host-side demultiplexer model
// that rebuilds each channel's stream, and directed cycle-exact checks of the framing rules.
module tb_rs232_tx_channel_arbiter;
    localparam int CH = 4;
    localparam int MB = 16;
    localparam logic [7:0] ESC = 8'hFE;

    logic          clock  = 1'b0;
    logic          resetn = 1'b0;
    logic [8*CH-1:0] idata = '0;
    logic [CH-1:0] ivalid = '0;
    logic [CH-1:0] iready;
    logic [7:0]    odata;
    logic          ovalid;
    logic          oready = 1'b0;

    rs232_tx_channel_arbiter #(.CHANNELS(CH), .MAX_BURST(MB)) dut (
        .clock(clock), .resetn(resetn), .idata(idata), .ivalid(ivalid),
        .iready(iready), .odata(odata), .ovalid(ovalid), .oready(oready)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit rand_mode = 1'b0;
    bit oready_val = 1'b1;
    logic [CH-1:0] hs = '0;
    logic [7:0] src_q [CH][$];
    logic [7:0] exp_q [CH][$];
    logic [7:0] out_q [$];
    int         acc_t [$];
    logic [7:0] acc_b [$];
    bit   pend_esc = 1'b0;
    int   cur_ch = -1;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic payload(input logic [7:0] b);
        logic [7:0] e;
        if (cur_ch < 0 || cur_ch >= CH) chk(1'b0, "payload_no_header", 32'(b), 32'(0));
        else if (exp_q[cur_ch].size() == 0) chk(1'b0, "payload_extra", 32'(b), 32'(cur_ch));
        else begin
            e = exp_q[cur_ch].pop_front();
            chk(b == e, "payload", 32'(b), 32'(e));
        end
    endtask

    // Host-side decoder: ESC,ESC is a payload ESC; ESC,n switches to channel n.
    task automatic decode(input logic [7:0] b);
        if (pend_esc) begin
            pend_esc = 1'b0;
            if (b == ESC) payload(ESC);
            else begin
                chk(int'(b) < CH && int'(b) != cur_ch, "header", 32'(b), 32'(cur_ch));
                cur_ch = int'(b);
            end
        end else if (b == ESC) pend_esc = 1'b1;
        else payload(b);
    endtask

    // Compare process: input handshakes feed the expected per-channel streams, output bytes are demultiplexed.
    always @(negedge clock) begin
        cyc++;
        if (!resetn) begin
            hs = '0;
            pend_esc = 1'b0;
            cur_ch = -1;
            prev_stall = 1'b0;
            for (int c = 0; c < CH; c++) exp_q[c].delete();
        end else begin
            hs = ivalid & iready;
            chk($countones(iready) <= 1 && (iready & ~ivalid) == '0, "iready_legal", 32'(iready), 32'(ivalid));
            if (prev_stall) chk(ovalid && odata == prev_data, "bp_hold", 32'({ovalid, odata}), 32'({1'b1, prev_data}));
            if (ovalid && !oready) chk(iready == '0, "bp_iready", 32'(iready), 32'(0));
            for (int c = 0; c < CH; c++) begin
                if (hs[c]) begin
                    exp_q[c].push_back(idata[8*c +: 8]);
                    acc_t.push_back(cyc);
                    acc_b.push_back(idata[8*c +: 8]);
                end
            end
            if (ovalid && oready) begin
                out_q.push_back(odata);
                decode(odata);
            end
            prev_stall = ovalid && !oready;
            prev_data  = odata;
        end
    end

    // Sources: AXI-style, valid held until accepted.
    always @(posedge clock) begin
        #1;
        for (int c = 0; c < CH; c++) begin
            if (hs[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
            if (src_q[c].size() == 0) ivalid[c] = 1'b0;
            else if (!ivalid[c] || hs[c]) ivalid[c] = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            idata[8*c +: 8] = (src_q[c].size() > 0) ? src_q[c][0] : 8'h00;
        end
        oready = rand_mode ? ($urandom_range(0, 2) != 0) : oready_val;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_out(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (out_q.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        #1;
        if (out_q.size() < n) chk(1'b0, name, 32'(out_q.size()), 32'(n));
    endtask

    task automatic cmp_out(input logic [7:0] e [$], input string name);
        chk(out_q.size() == e.size(), name, 32'(out_q.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < out_q.size(); i++)
            chk(out_q[i] == e[i], name, 32'(out_q[i]), 32'(e[i]));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] e [$];
        logic [7:0] bb [$];
        int k;
        int g;

        repeat (2) @(posedge clock);
        #3;
        chk(odata == 8'h00 && ovalid == 1'b0, "reset_out", 32'({ovalid, odata}), 32'(0));
        chk(iready == '0, "reset_iready", 32'(iready), 32'(0));
        resetn = 1'b1;

        // Header path on ch2: ESC at c1, channel at c2 (byte accepted), data at c3.
        tick();
        out_q.delete();
        src_q[2].push_back(8'h11);
        src_q[2].push_back(8'h22);
        @(posedge clock);
        @(negedge clock); chk(!ovalid && iready == '0, "hdr_c0", 32'({ovalid, iready}), 32'(0));
        @(negedge clock); chk(ovalid && odata == ESC, "hdr_c1_esc", 32'(odata), 32'(ESC));
        @(negedge clock); chk(ovalid && odata == 8'h02, "hdr_c2_ch", 32'(odata), 32'(2));
                          chk(iready == 4'b0100, "hdr_c2_ready", 32'(iready), 32'(4));
        @(negedge clock); chk(ovalid && odata == 8'h11, "hdr_c3_data", 32'(odata), 32'(8'h11));
        wait_out(4, 20, "t1_timeout");
        e = '{8'hFE, 8'h02, 8'h11, 8'h22};
        cmp_out(e, "t1_stream");

        // Same channel after a gap: no header, accepted c1, visible c2.
        repeat (4) @(posedge clock);
        #2;
        out_q.delete();
        src_q[2].push_back(8'h33);
        @(posedge clock);
        @(negedge clock); chk(iready == '0, "same_c0", 32'(iready), 32'(0));
        @(negedge clock); chk(iready == 4'b0100, "same_c1_ready", 32'(iready), 32'(4));
        @(negedge clock); chk(ovalid && odata == 8'h33, "same_c2_data", 32'(odata), 32'(8'h33));
        wait_out(1, 20, "t1b_timeout");
        e = '{8'h33};
        cmp_out(e, "t1b_stream");

        // Stuffing on ch3: iready low during the stuff cycle.
        repeat (4) @(posedge clock);
        #2;
        out_q.delete();
        src_q[3].push_back(ESC);
        src_q[3].push_back(8'h41);
        @(posedge clock);
        @(negedge clock);
        @(negedge clock); chk(ovalid && odata == ESC, "stuff_c1", 32'(odata), 32'(ESC));
        @(negedge clock); chk(ovalid && odata == 8'h03 && iready == 4'b1000, "stuff_c2", 32'({iready, odata}), 32'({4'b1000, 8'h03}));
        @(negedge clock); chk(ovalid && odata == ESC && iready == '0, "stuff_c3", 32'({iready, odata}), 32'({4'b0000, ESC}));
        @(negedge clock); chk(ovalid && odata == ESC && iready == 4'b1000, "stuff_c4", 32'({iready, odata}), 32'({4'b1000, ESC}));
        @(negedge clock); chk(ovalid && odata == 8'h41, "stuff_c5", 32'(odata), 32'(8'h41));
        wait_out(5, 20, "t3_timeout");
        e = '{8'hFE, 8'h03, 8'hFE, 8'hFE, 8'h41};
        cmp_out(e, "t3_stream");

        // Burst limit on ch1 with one stuffed byte: 16 payload bytes, then IDLE, then 4 more, no new header.
        repeat (4) @(posedge clock);
        #2;
        out_q.delete();
        acc_t.delete();
        acc_b.delete();
        bb.delete();
        for (int i = 0; i < 20; i++) bb.push_back((i == 5) ? ESC : 8'(8'h50 + i));
        foreach (bb[i]) src_q[1].push_back(bb[i]);
        k = 0;
        while (acc_t.size() < 20 && k < 200) begin @(negedge clock); k++; end
        #1;
        chk(acc_t.size() == 20, "burst_accepts", 32'(acc_t.size()), 32'(20));
        for (int i = 1; i < acc_t.size(); i++) begin
            g = 1 + ((acc_b[i-1] == ESC) ? 1 : 0) + ((i % MB == 0) ? 2 : 0);
            chk(acc_t[i] - acc_t[i-1] == g, "burst_gap", 32'(acc_t[i] - acc_t[i-1]), 32'(g));
        end
        e = '{8'hFE, 8'h01};
        foreach (bb[i]) begin
            e.push_back(bb[i]);
            if (bb[i] == ESC) e.push_back(ESC);
        end
        wait_out(e.size(), 50, "t4_timeout");
        cmp_out(e, "t4_stream");

        // Round robin: ch0 and ch1 both hold 20 bytes.
        repeat (4) @(posedge clock);
        #2;
        out_q.delete();
        for (int i = 0; i < 20; i++) begin
            src_q[0].push_back(8'(8'h10 + i));
            src_q[1].push_back(8'(8'h80 + i));
        end
        e = '{8'hFE, 8'h00};
        for (int i = 0; i < 16; i++) e.push_back(8'(8'h10 + i));
        e.push_back(ESC); e.push_back(8'h01);
        for (int i = 0; i < 16; i++) e.push_back(8'(8'h80 + i));
        e.push_back(ESC); e.push_back(8'h00);
        for (int i = 16; i < 20; i++) e.push_back(8'(8'h10 + i));
        e.push_back(ESC); e.push_back(8'h01);
        for (int i = 16; i < 20; i++) e.push_back(8'(8'h80 + i));
        wait_out(e.size(), 300, "t5_timeout");
        cmp_out(e, "t5_stream");

        // Reset while a stuff pair is half sent on ch3.
        repeat (4) @(posedge clock);
        #2;
        src_q[3].push_back(ESC);
        src_q[3].push_back(8'h41);
        k = 0;
        while (!(ovalid && odata == 8'h03) && k < 30) begin @(negedge clock); k++; end
        chk(ovalid && odata == 8'h03, "rst_find_hdr", 32'(odata), 32'(8'h03));
        oready_val = 1'b0;
        @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        chk(!ovalid && odata == 8'h00 && iready == '0, "rst_async", 32'({iready, ovalid, odata}), 32'(0));
        oready_val = 1'b1;
        repeat (2) @(posedge clock);
        #3;
        resetn = 1'b1;
        out_q.delete();
        wait_out(3, 30, "t6_timeout");
        e = '{8'hFE, 8'h03, 8'h41};
        cmp_out(e, "t6_stream");

        // Random mixed 3-channel stream with random oready and source gaps.
        repeat (4) @(posedge clock);
        #2;
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            src_q[0].push_back(($urandom_range(0, 3) == 0) ? ESC : 8'($urandom_range(0, 255)));
            src_q[1].push_back(($urandom_range(0, 3) == 0) ? ESC : 8'($urandom_range(0, 255)));
            src_q[3].push_back(($urandom_range(0, 3) == 0) ? ESC : 8'($urandom_range(0, 255)));
        end
        k = 0;
        while ((src_q[0].size() + src_q[1].size() + src_q[3].size()) > 0 && k < 5000) begin
            @(posedge clock);
            k++;
        end
        chk((src_q[0].size() + src_q[1].size() + src_q[3].size()) == 0, "rand_src_drain",
            32'(src_q[0].size() + src_q[1].size() + src_q[3].size()), 32'(0));
        rand_mode = 1'b0;
        oready_val = 1'b1;
        k = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[3].size()) > 0 && k < 200) begin
            @(negedge clock);
            k++;
        end
        repeat (3) @(negedge clock);
        for (int c = 0; c < CH; c++) chk(exp_q[c].size() == 0, "rand_exp_drain", 32'(exp_q[c].size()), 32'(0));
        chk(!ovalid && !pend_esc, "rand_idle", 32'({ovalid, pend_esc}), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
